// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display multiplexer and its
// receive-side demultiplexer.
package seven_seg_pkg;

  localparam int WIDTH_SEG = 4;
  localparam int WIDTH_EN  = 4;

  localparam logic [WIDTH_EN-1:0] EN_D0    = 4'b1110;
  localparam logic [WIDTH_EN-1:0] EN_D1    = 4'b1101;
  localparam logic [WIDTH_EN-1:0] EN_D2    = 4'b1011;
  localparam logic [WIDTH_EN-1:0] EN_D3    = 4'b0111;
  localparam logic [WIDTH_EN-1:0] EN_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } dig_idx_e;

endpackage

// File: rtl/seven_seg_en_decode.sv
// Classifies a registered active-low enable pattern as a digit index, the
// blank pattern, or an illegal pattern.
module seven_seg_en_decode
  import seven_seg_pkg::*;
(
  input  logic [WIDTH_EN-1:0] en_i,
  output logic [1:0]          idx_o,
  output logic                legal_o,
  output logic                blank_o
);

  always_comb begin
    idx_o   = 2'd0;
    legal_o = 1'b0;
    blank_o = 1'b0;
    case (en_i)
      EN_D0:    begin idx_o = 2'd0; legal_o = 1'b1; end
      EN_D1:    begin idx_o = 2'd1; legal_o = 1'b1; end
      EN_D2:    begin idx_o = 2'd2; legal_o = 1'b1; end
      EN_D3:    begin idx_o = 2'd3; legal_o = 1'b1; end
      EN_BLANK: blank_o = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/seven_seg_demux.sv
// Rebuilds the four digit values from a multiplexed display bus, filters
// short glitches, checks scan order and flags complete frames.
module seven_seg_demux #(
  parameter int WIDTH_SEG = 4,
  parameter int SETTLE    = 2,
  parameter int ERR_W     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [3:0]           i_en,
  input  logic [WIDTH_SEG-1:0] i_seg,
  output logic [WIDTH_SEG-1:0] o_dig1,
  output logic [WIDTH_SEG-1:0] o_dig2,
  output logic [WIDTH_SEG-1:0] o_dig3,
  output logic [WIDTH_SEG-1:0] o_dig4,
  output logic                 o_valid,
  output logic                 o_frame,
  output logic                 o_err,
  output logic [ERR_W-1:0]     o_err_cnt
);
  import seven_seg_pkg::*;

  localparam int HW = $clog2(SETTLE + 1);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [HW-1:0] H_MAX = HW'(SETTLE);

  logic [3:0]           r_en_q;
  logic [WIDTH_SEG-1:0] r_seg_q;
  logic [HW-1:0]        h_q, h_d;
  logic                 captured_q, captured_d;
  logic [3:0]           mask_q, mask_d;
  dig_idx_e             last_q;
  logic [WIDTH_SEG-1:0] dig_q [4];

  logic [1:0] idx;
  logic       legal, blank;
  logic       restart, armed, doCap, doIll, inOrder;
  logic       frame_d, err_d;

  seven_seg_en_decode u_decode (
    .en_i    (r_en_q),
    .idx_o   (idx),
    .legal_o (legal),
    .blank_o (blank)
  );

  // The dwell counter tracks how long the registered pattern has held; a
  // new pattern starts a fresh dwell that may be captured once.
  always_comb begin
    restart    = {i_en, i_seg} != {r_en_q, r_seg_q};
    h_d        = restart ? H_ONE : ((h_q == H_MAX) ? H_MAX : HW'(h_q + H_ONE));
    armed      = (h_q == H_MAX) && !captured_q;
    doCap      = armed && legal;
    doIll      = armed && !legal && !blank;
    inOrder    = (mask_q == 4'd0) || (idx == last_q) || (idx == 2'(last_q + 2'd1));
    captured_d = !restart && (captured_q || doCap || doIll);
    mask_d     = mask_q;
    frame_d    = 1'b0;
    err_d      = 1'b0;
    if (doIll) begin
      mask_d = 4'd0;
      err_d  = 1'b1;
    end else if (doCap) begin
      if (inOrder) begin
        mask_d = mask_q | (4'd1 << idx);
      end else begin
        mask_d = 4'd1 << idx;
        err_d  = 1'b1;
      end
      if (mask_d == 4'hF) begin
        frame_d = 1'b1;
        mask_d  = 4'd0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en_q     <= EN_BLANK;
      r_seg_q    <= '0;
      h_q        <= '0;
      captured_q <= 1'b0;
      mask_q     <= 4'd0;
      last_q     <= DIG0;
      for (int i = 0; i < 4; i++) dig_q[i] <= '0;
      o_valid    <= 1'b0;
      o_frame    <= 1'b0;
      o_err      <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      r_en_q     <= i_en;
      r_seg_q    <= i_seg;
      h_q        <= h_d;
      captured_q <= captured_d;
      mask_q     <= mask_d;
      o_frame    <= frame_d;
      o_err      <= err_d;
      if (frame_d) o_valid <= 1'b1;
      if (err_d && (o_err_cnt != {ERR_W{1'b1}})) o_err_cnt <= o_err_cnt + 1'b1;
      if (doCap) begin
        last_q     <= dig_idx_e'(idx);
        dig_q[idx] <= r_seg_q;
      end
    end
  end

  assign o_dig1 = dig_q[0];
  assign o_dig2 = dig_q[1];
  assign o_dig3 = dig_q[2];
  assign o_dig4 = dig_q[3];

endmodule

// File: tb/tb_seven_seg_demux.sv
// Directed bench for seven_seg_demux: expected snapshots are queued as each
// scenario is driven and compared once the display traffic has settled.
module tb_seven_seg_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic [3:0] seg;
  logic [3:0] dig1, dig2, dig3, dig4;
  logic       valid, frame, err;
  logic [7:0] errCnt;

  int total = 0;
  int bad = 0;
  int framePulses = 0;
  int errPulses = 0;

  typedef struct {
    logic [3:0] d1, d2, d3, d4;
    logic       valid;
    logic [7:0] errCnt;
    int         frames;
    int         errs;
  } expT;

  expT   expQ[$];
  string tagQ[$];

  always #5 clk = ~clk;

  seven_seg_demux #(.WIDTH_SEG(4), .SETTLE(2), .ERR_W(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_seg     (seg),
    .o_dig1    (dig1),
    .o_dig2    (dig2),
    .o_dig3    (dig3),
    .o_dig4    (dig4),
    .o_valid   (valid),
    .o_frame   (frame),
    .o_err     (err),
    .o_err_cnt (errCnt)
  );

  // Pulses are tallied just after each edge so single-cycle events are not missed.
  always @(posedge clk) begin
    #1;
    if (frame === 1'b1) framePulses++;
    if (err === 1'b1) errPulses++;
  end

  task applyStimulus(input logic [3:0] e, input logic [3:0] s, input int n);
    en  = e;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task pushExpect(input string tag, input logic [3:0] d1, input logic [3:0] d2,
                  input logic [3:0] d3, input logic [3:0] d4, input logic v,
                  input logic [7:0] cnt, input int frames, input int errs);
    expT e;
    e.d1 = d1; e.d2 = d2; e.d3 = d3; e.d4 = d4;
    e.valid = v; e.errCnt = cnt; e.frames = frames; e.errs = errs;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task checkVal(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task checkOutput();
    expT   e;
    string t;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkVal({t, ".dig1"}, 32'(dig1), 32'(e.d1));
      checkVal({t, ".dig2"}, 32'(dig2), 32'(e.d2));
      checkVal({t, ".dig3"}, 32'(dig3), 32'(e.d3));
      checkVal({t, ".dig4"}, 32'(dig4), 32'(e.d4));
      checkVal({t, ".valid"}, 32'(valid), 32'(e.valid));
      checkVal({t, ".errCnt"}, 32'(errCnt), 32'(e.errCnt));
      checkVal({t, ".frames"}, 32'(framePulses), 32'(e.frames));
      checkVal({t, ".errPulses"}, 32'(errPulses), 32'(e.errs));
      checkVal({t, ".frameIdle"}, 32'(frame), 32'd0);
      checkVal({t, ".errIdle"}, 32'(err), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 4'hF;
    seg = 4'h0;
    repeat (3) @(negedge clk);
    pushExpect("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 0, 0);
    checkOutput();
    rst = 1'b0;
    applyStimulus(4'hF, 4'h0, 2);

    // Normal scan, checked before and after the fourth digit.
    applyStimulus(4'hE, 4'h3, 4);
    applyStimulus(4'hD, 4'h7, 4);
    applyStimulus(4'hB, 4'hA, 4);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("scanPartial", 4'h3, 4'h7, 4'hA, 4'h0, 1'b0, 8'd0, 0, 0);
    checkOutput();
    applyStimulus(4'h7, 4'h5, 4);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("scanFull", 4'h3, 4'h7, 4'hA, 4'h5, 1'b1, 8'd0, 1, 0);
    checkOutput();

    // One-cycle glitch between two real dwells.
    applyStimulus(4'hE, 4'h1, 4);
    applyStimulus(4'hD, 4'h9, 1);
    applyStimulus(4'hD, 4'h4, 4);
    applyStimulus(4'hB, 4'h8, 4);
    applyStimulus(4'h7, 4'h2, 4);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("glitch", 4'h1, 4'h4, 4'h8, 4'h2, 1'b1, 8'd0, 2, 0);
    checkOutput();

    // Illegal enable held three cycles.
    applyStimulus(4'hE, 4'hC, 4);
    applyStimulus(4'hC, 4'h0, 3);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("illegal", 4'hC, 4'h4, 4'h8, 4'h2, 1'b1, 8'd1, 2, 1);
    checkOutput();

    // Mask was cleared, so digit 1 resyncs and 1,2,3,0 closes a frame.
    applyStimulus(4'hD, 4'hD, 4);
    applyStimulus(4'hB, 4'h6, 4);
    applyStimulus(4'h7, 4'h7, 4);
    applyStimulus(4'hE, 4'h0, 4);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("resyncFrame", 4'h0, 4'hD, 4'h6, 4'h7, 1'b1, 8'd1, 3, 1);
    checkOutput();

    // Out-of-order skip from digit 0 to digit 2.
    applyStimulus(4'hE, 4'h1, 4);
    applyStimulus(4'hB, 4'hB, 4);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("outOfOrder", 4'h1, 4'hD, 4'hB, 4'h7, 1'b1, 8'd2, 3, 2);
    checkOutput();
    applyStimulus(4'h7, 4'hF, 4);
    applyStimulus(4'hE, 4'h2, 4);
    applyStimulus(4'hD, 4'h3, 4);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("orderRecover", 4'h2, 4'h3, 4'hB, 4'hF, 1'b1, 8'd2, 4, 2);
    checkOutput();

    // Segment change inside one enable dwell is a re-capture only.
    applyStimulus(4'hE, 4'h2, 3);
    applyStimulus(4'hE, 4'h6, 3);
    applyStimulus(4'hD, 4'h8, 4);
    applyStimulus(4'hB, 4'h9, 4);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("segChange", 4'h6, 4'h8, 4'h9, 4'hF, 1'b1, 8'd2, 4, 2);
    checkOutput();
    applyStimulus(4'h7, 4'hA, 4);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("segChangeFrame", 4'h6, 4'h8, 4'h9, 4'hA, 1'b1, 8'd2, 5, 2);
    checkOutput();

    // Reset after two captures of a new frame.
    applyStimulus(4'hE, 4'h1, 4);
    applyStimulus(4'hD, 4'h2, 4);
    en  = 4'hF;
    seg = 4'h0;
    rst = 1'b1;
    @(negedge clk);
    pushExpect("midReset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 5, 2);
    checkOutput();
    rst = 1'b0;
    applyStimulus(4'hE, 4'h4, 4);
    applyStimulus(4'hD, 4'h5, 4);
    applyStimulus(4'hB, 4'h6, 4);
    applyStimulus(4'h7, 4'h7, 4);
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("postReset", 4'h4, 4'h5, 4'h6, 4'h7, 1'b1, 8'd0, 6, 2);
    checkOutput();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'hC, 4'h0, 2);
      applyStimulus(4'hF, 4'h0, 1);
    end
    applyStimulus(4'hF, 4'h0, 3);
    pushExpect("saturate", 4'h4, 4'h5, 4'h6, 4'h7, 1'b1, 8'hFF, 6, 302);
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
